// File: rtl/ux607_rst_seq_if.sv
// Request/status bundle between the reset sequencer and the SoC reset consumers.
interface ux607_rst_seq_if;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       dbg_rst_req;
  logic       cause_clr;
  logic       bus_rst_n;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       rst_done;
  logic [2:0] rst_cause;

  modport master (
    output sw_rst_req, wdt_rst_req, dbg_rst_req, cause_clr,
    input  bus_rst_n, periph_rst_n, core_rst_n, rst_done, rst_cause
  );

  modport slave (
    input  sw_rst_req, wdt_rst_req, dbg_rst_req, cause_clr,
    output bus_rst_n, periph_rst_n, core_rst_n, rst_done, rst_cause
  );
endinterface

// File: rtl/ux607_rst_seq.sv
// UX607 reset sequencer: staged bus -> peripheral -> core release with a sticky cause code.
module ux607_rst_seq #(
  parameter int HOLD_CYC        = 16,
  parameter int BUS2PERIPH_CYC  = 4,
  parameter int PERIPH2CORE_CYC = 4,
  parameter int CNT_W           = 8
) (
  input  logic             sys_clk,
  input  logic             por_rst_n,
  ux607_rst_seq_if.slave   rif
);

  localparam logic [1:0] HOLD       = 2'd0;
  localparam logic [1:0] BUS_REL    = 2'd1;
  localparam logic [1:0] PERIPH_REL = 2'd2;
  localparam logic [1:0] RUN        = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] B2P_LAST  = CNT_W'(BUS2PERIPH_CYC - 1);
  localparam logic [CNT_W-1:0] P2C_LAST  = CNT_W'(PERIPH2CORE_CYC - 1);

  localparam logic [2:0] CAUSE_NONE = 3'b000;
  localparam logic [2:0] CAUSE_POR  = 3'b001;
  localparam logic [2:0] CAUSE_SW   = 3'b010;
  localparam logic [2:0] CAUSE_WDT  = 3'b011;
  localparam logic [2:0] CAUSE_DBG  = 3'b100;

  logic [1:0]       sync_pipe;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             bus_q, periph_q, core_q, done_q;
  logic [2:0]       cause_q;
  logic             req_any;
  logic [2:0]       req_cause;

  assign req_any = rif.sw_rst_req | rif.wdt_rst_req | rif.dbg_rst_req;

  always_comb begin
    req_cause = CAUSE_NONE;
    if (rif.wdt_rst_req)      req_cause = CAUSE_WDT;
    else if (rif.dbg_rst_req) req_cause = CAUSE_DBG;
    else if (rif.sw_rst_req)  req_cause = CAUSE_SW;
  end

  // sync_pipe[1] gates HOLD counting so POR deassertion is seen two edges late
  always_ff @(posedge sys_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      sync_pipe <= 2'b00;
      state     <= HOLD;
      cnt       <= '0;
      bus_q     <= 1'b0;
      periph_q  <= 1'b0;
      core_q    <= 1'b0;
      done_q    <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else begin
      sync_pipe <= {sync_pipe[0], 1'b1};
      if (req_any) begin
        state    <= HOLD;
        cnt      <= '0;
        bus_q    <= 1'b0;
        periph_q <= 1'b0;
        core_q   <= 1'b0;
        done_q   <= 1'b0;
        cause_q  <= req_cause;
      end else begin
        if (rif.cause_clr) cause_q <= CAUSE_NONE;
        case (state)
          HOLD: begin
            if (sync_pipe[1]) begin
              if (cnt == HOLD_LAST) begin
                state <= BUS_REL;
                cnt   <= '0;
                bus_q <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          BUS_REL: begin
            if (cnt == B2P_LAST) begin
              state    <= PERIPH_REL;
              cnt      <= '0;
              periph_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PERIPH_REL: begin
            if (cnt == P2C_LAST) begin
              state  <= RUN;
              cnt    <= '0;
              core_q <= 1'b1;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rif.bus_rst_n    = bus_q;
  assign rif.periph_rst_n = periph_q;
  assign rif.core_rst_n   = core_q;
  assign rif.rst_done     = done_q;
  assign rif.rst_cause    = cause_q;

endmodule

// File: tb/tb_ux607_rst_seq.sv
// Directed + randomized bench for ux607_rst_seq against an edge-count reference model.
module tb_ux607_rst_seq;
  localparam int HOLD = 16;
  localparam int B2P  = 4;
  localparam int P2C  = 4;

  logic sys_clk;
  logic por_rst_n;
  ux607_rst_seq_if rif ();

  ux607_rst_seq #(.HOLD_CYC(HOLD), .BUS2PERIPH_CYC(B2P), .PERIPH2CORE_CYC(P2C), .CNT_W(8)) dut (
    .sys_clk  (sys_clk),
    .por_rst_n(por_rst_n),
    .rif      (rif.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Model: n = qualifying edges since the last reset event; releases are thresholds on n.
  int         eds;
  int         n;
  logic [2:0] m_cause;

  task automatic model_por();
    eds = 0; n = 0; m_cause = 3'b001;
  endtask

  task automatic model_edge();
    logic any;
    any = rif.sw_rst_req | rif.wdt_rst_req | rif.dbg_rst_req;
    if (!por_rst_n) begin
      model_por();
    end else begin
      if (eds < 1000) eds++;
      if (any) begin
        n = 0;
        if (rif.wdt_rst_req)      m_cause = 3'b011;
        else if (rif.dbg_rst_req) m_cause = 3'b100;
        else                      m_cause = 3'b010;
      end else begin
        if (rif.cause_clr) m_cause = 3'b000;
        if (eds >= 3 && n < 1000) n++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bus_rst_n",    {2'b0, rif.bus_rst_n},    {2'b0, n >= HOLD});
    chk("periph_rst_n", {2'b0, rif.periph_rst_n}, {2'b0, n >= HOLD + B2P});
    chk("core_rst_n",   {2'b0, rif.core_rst_n},   {2'b0, n >= HOLD + B2P + P2C});
    chk("rst_done",     {2'b0, rif.rst_done},     {2'b0, n >= HOLD + B2P + P2C});
    chk("rst_cause",    rif.rst_cause,            m_cause);
    chk("order", {2'b0, (!rif.core_rst_n || rif.periph_rst_n) && (!rif.periph_rst_n || rif.bus_rst_n)}, 3'b001);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_all();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic set_req(input logic sw, input logic wdt, input logic dbg, input logic clr);
    rif.sw_rst_req  = sw;
    rif.wdt_rst_req = wdt;
    rif.dbg_rst_req = dbg;
    rif.cause_clr   = clr;
  endtask

  initial begin
    set_req(0, 0, 0, 0);
    por_rst_n = 1'b1;
    model_por();
    #2 por_rst_n = 1'b0;
    #1 check_all();
    ticks(3);

    // POR release: bus after edge 18, periph after 22, core/done after 26
    por_rst_n = 1'b1;
    ticks(17);
    chk("por_bus_pre18", {2'b0, rif.bus_rst_n}, 3'b000);
    tick();
    chk("por_bus_at18", {2'b0, rif.bus_rst_n}, 3'b001);
    ticks(3);
    chk("por_periph_pre22", {2'b0, rif.periph_rst_n}, 3'b000);
    tick();
    chk("por_periph_at22", {2'b0, rif.periph_rst_n}, 3'b001);
    ticks(4);
    chk("por_done_at26", {2'b0, rif.rst_done}, 3'b001);
    chk("por_cause", rif.rst_cause, 3'b001);
    ticks(3);

    // 1-cycle watchdog pulse in RUN
    set_req(0, 1, 0, 0);
    tick();
    set_req(0, 0, 0, 0);
    chk("wdt_core_drop", {2'b0, rif.core_rst_n}, 3'b000);
    chk("wdt_cause", rif.rst_cause, 3'b011);
    ticks(28);

    // software request held 10 cycles
    set_req(1, 0, 0, 0);
    ticks(10);
    set_req(0, 0, 0, 0);
    ticks(15);
    chk("sw_bus_pre", {2'b0, rif.bus_rst_n}, 3'b000);
    tick();
    chk("sw_bus_rel", {2'b0, rif.bus_rst_n}, 3'b001);
    chk("sw_cause", rif.rst_cause, 3'b010);
    ticks(12);

    // all three together, then debug alone during PERIPH_REL
    set_req(1, 1, 1, 0);
    tick();
    set_req(0, 0, 0, 0);
    chk("prio_cause", rif.rst_cause, 3'b011);
    ticks(21);
    chk("mid_periph", {2'b0, rif.periph_rst_n}, 3'b001);
    set_req(0, 0, 1, 0);
    tick();
    set_req(0, 0, 0, 0);
    chk("dbg_bus_drop", {2'b0, rif.bus_rst_n}, 3'b000);
    chk("dbg_cause", rif.rst_cause, 3'b100);
    ticks(28);

    // asynchronous POR mid-RUN
    #2 por_rst_n = 1'b0;
    model_por();
    #1;
    chk("apor_bus",   {2'b0, rif.bus_rst_n}, 3'b000);
    chk("apor_core",  {2'b0, rif.core_rst_n}, 3'b000);
    chk("apor_done",  {2'b0, rif.rst_done}, 3'b000);
    chk("apor_cause", rif.rst_cause, 3'b001);
    ticks(2);
    por_rst_n = 1'b1;
    ticks(30);

    // cause_clr alone, then with sw request
    set_req(0, 0, 0, 1);
    tick();
    chk("clr_cause", rif.rst_cause, 3'b000);
    set_req(1, 0, 0, 1);
    tick();
    set_req(0, 0, 0, 0);
    chk("clr_vs_sw", rif.rst_cause, 3'b010);
    ticks(30);

    // randomized requests
    for (int i = 0; i < 400; i++) begin
      set_req($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
      tick();
    end
    set_req(0, 0, 0, 0);
    ticks(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
